// File: rtl/frame_cmd_queue.sv
// frame_cmd_queue
//   Avalon-MM write-side front end for the sprite command bus. CPU writes
//   to address 0 are buffered in a DEPTH-entry FIFO and replayed one word
//   per clock onto cmd_out, which feeds the writedata input of every sprite
//   display module. A buffer-swap word (bits[20:17] == 4'hF) issues with a
//   one-cycle frame_irq pulse and bumps a 16-bit frame counter.
//
//   Build option CMDQ_FRAME_SYNC_EN:
//     defined   - a swap word at the FIFO head is held until the next
//                 vertical-blank edge (vcount reaching VACTIVE), so all of a
//                 frame's updates reach the back buffer before the swap.
//     undefined - swap words drain like ordinary words; vcount is unused and
//                 the waiting status bit reads 0.
//
// Parameters
//   DEPTH    FIFO entries, power of two, 4..64
//   VACTIVE  vcount value of the first blanking line
// Ports
//   clk, reset     system clock, async active-high reset
//   chipselect     Avalon select
//   write, read    Avalon strobes
//   address        0 = command FIFO, 1 = control/status
//   writedata      Avalon write data
//   readdata       registered read data, holds until the next read
//   vcount         current VGA line
//   cmd_out        command word to display modules, 0 when idle
//   frame_irq      one-cycle pulse when a swap word is issued
//
// Control write (address 1): bit0 clears overflow, bit1 flushes the FIFO.
// Status read (address 1):
//   {frame_count[15:0], overflow, waiting, full, empty, 5'b0, level[6:0]}
module frame_cmd_queue #(
  parameter int DEPTH   = 16,
  parameter int VACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic        address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        frame_irq
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [6:0]    r_level;
  logic          r_overflow;
  logic [15:0]   r_frame_count;
  logic [31:0]   r_cmd;
  logic          r_irq;
  logic [31:0]   r_readdata;

  logic          w_push_req;
  logic          w_ctrl_wr;
  logic          w_flush;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_issue_swap;
  logic [31:0]   w_head;
  logic          w_head_swap;
  logic          w_waiting;
  logic [31:0]   w_status;

  assign w_push_req  = chipselect & write & ~address;
  assign w_ctrl_wr   = chipselect & write & address;
  assign w_flush     = w_ctrl_wr & writedata[1];
  assign w_empty     = (r_level == 7'd0);
  assign w_full      = (r_level == 7'(DEPTH));
  // A full FIFO rejects the push even if a pop frees a slot this cycle.
  assign w_push      = w_push_req & ~w_full;
  assign w_head      = r_mem[r_rptr];
  assign w_head_swap = (w_head[20:17] == 4'hF);

`ifdef CMDQ_FRAME_SYNC_EN
  typedef enum logic {S_RUN, S_WAIT_VBL} state_t;
  state_t     r_state;
  state_t     w_state_nxt;
  logic [9:0] r_vcount_q;
  logic       w_vbl_edge;

  // Only the first cycle of the blanking line counts; holding vcount at
  // VACTIVE does not re-trigger.
  assign w_vbl_edge = (vcount == 10'(VACTIVE)) && (r_vcount_q != 10'(VACTIVE));
  assign w_waiting  = (r_state == S_WAIT_VBL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_vcount_q <= 10'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_vcount_q <= vcount;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_issue_swap = 1'b0;
    case (r_state)
      S_RUN: begin
        // A swap at the head parks the queue; a vblank edge seen here is
        // deliberately not remembered.
        if (!w_empty) begin
          if (w_head_swap) w_state_nxt = S_WAIT_VBL;
          else             w_pop       = 1'b1;
        end
      end
      S_WAIT_VBL: begin
        // The head is always the parked swap word while in this state.
        if (w_vbl_edge) begin
          w_pop        = 1'b1;
          w_issue_swap = 1'b1;
          w_state_nxt  = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
    if (w_flush) begin
      w_state_nxt  = S_RUN;
      w_pop        = 1'b0;
      w_issue_swap = 1'b0;
    end
  end
`else
  logic w_unused_vcount;
  assign w_unused_vcount = ^vcount;
  assign w_waiting       = 1'b0;

  always_comb begin
    w_pop        = 1'b0;
    w_issue_swap = 1'b0;
    if (!w_empty && !w_flush) begin
      w_pop        = 1'b1;
      w_issue_swap = w_head_swap;
    end
  end
`endif

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= 7'd0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= 7'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 7'd1;
        2'b01:   r_level <= r_level - 7'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Issue stage: w_pop is already suppressed by a flush, so cmd_out goes
  // to 0 the cycle after a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd         <= 32'd0;
      r_irq         <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_cmd <= w_pop ? w_head : 32'd0;
      r_irq <= w_issue_swap;
      if (w_issue_swap) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_overflow <= 1'b0;
    else if (w_push_req && w_full)     r_overflow <= 1'b1;
    else if (w_ctrl_wr && writedata[0]) r_overflow <= 1'b0;
  end

  assign w_status = {r_frame_count, r_overflow, w_waiting, w_full, w_empty,
                     5'b0, r_level};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_readdata <= 32'd0;
    else if (chipselect && read) r_readdata <= address ? w_status : 32'd0;
  end

  assign cmd_out   = r_cmd;
  assign frame_irq = r_irq;
  assign readdata  = r_readdata;

endmodule

// File: tb/tb_frame_cmd_queue.sv
module tb_frame_cmd_queue;
  localparam int DEPTH   = 16;
  localparam int VACTIVE = 480;
`ifdef CMDQ_FRAME_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect, write, read, address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;
  logic        frame_irq;

  frame_cmd_queue #(.DEPTH(DEPTH), .VACTIVE(VACTIVE)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .read(read), .address(address), .writedata(writedata),
    .readdata(readdata), .vcount(vcount), .cmd_out(cmd_out),
    .frame_irq(frame_irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
  endtask

  // Reference model: queue of pending words plus a "parked on swap" flag.
  logic [31:0] m_q[$];
  bit          m_wait;
  logic [31:0] m_cmd, m_rd;
  bit          m_irq, m_ovf;
  logic [15:0] m_fc;
  logic [9:0]  m_vq;

  function automatic bit is_swap(input logic [31:0] w);
    return w[20:17] == 4'hF;
  endfunction

  function automatic logic [31:0] m_status();
    logic [6:0] lvl;
    lvl = 7'(m_q.size());
    return {m_fc, m_ovf, m_wait, (m_q.size() == DEPTH), (m_q.size() == 0), 5'b0, lvl};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_wait = 0; m_cmd = 0; m_rd = 0; m_irq = 0; m_ovf = 0; m_fc = 0; m_vq = 0;
  endtask

  // One clock edge worth of behaviour, from the inputs present at the edge.
  task automatic model_step();
    logic [31:0] st;
    bit full_now, vbl, flush;
    st       = m_status();
    full_now = (m_q.size() == DEPTH);
    vbl      = (vcount == 10'(VACTIVE)) && (m_vq != 10'(VACTIVE));
    flush    = chipselect && write && address && writedata[1];
    m_cmd = 0;
    m_irq = 0;
    if (flush) begin
      m_q.delete();
      m_wait = 0;
    end else if (SYNC) begin
      if (m_wait) begin
        if (vbl) begin
          m_cmd = m_q.pop_front();
          m_irq = 1; m_fc++; m_wait = 0;
        end
      end else if (m_q.size() > 0) begin
        if (is_swap(m_q[0])) m_wait = 1;
        else                 m_cmd = m_q.pop_front();
      end
    end else if (m_q.size() > 0) begin
      m_cmd = m_q.pop_front();
      if (is_swap(m_cmd)) begin m_irq = 1; m_fc++; end
    end
    if (chipselect && write && !address) begin
      if (full_now) m_ovf = 1;
      else          m_q.push_back(writedata);
    end
    if (chipselect && write && address && writedata[0]) m_ovf = 0;
    if (chipselect && read) m_rd = address ? st : 32'd0;
    m_vq = vcount;
  endtask

  task automatic idle_inputs();
    chipselect = 0; write = 0; read = 0; address = 0; writedata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("cmd_out", cmd_out, m_cmd);
    chk("frame_irq", {31'b0, frame_irq}, {31'b0, m_irq});
    chk("readdata", readdata, m_rd);
    idle_inputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [31:0] w);
    chipselect = 1; write = 1; address = 0; writedata = w;
    tick();
  endtask

  task automatic ctrl(input logic [31:0] v);
    chipselect = 1; write = 1; address = 1; writedata = v;
    tick();
  endtask

  task automatic rd_status();
    chipselect = 1; read = 1; address = 1;
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_out", cmd_out, 32'd0);
    chk("rst_irq", {31'b0, frame_irq}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    reset = 0;
  endtask

  logic [31:0] w;
  int          vc;
  int          r;

  initial begin
    reset  = 1;
    vcount = 10'd100;
    idle_inputs();
    model_reset();
    do_reset();

    // First word latency and one-cycle width.
    push(32'h04030005);
    chk("t1_n1", cmd_out, 32'd0);
    tick();
    chk("t1_n2", cmd_out, 32'h04030005);
    tick();
    chk("t1_n3", cmd_out, 32'd0);
    rd_status();
    chk("t1_level", {25'b0, readdata[6:0]}, 32'd0);
    chk("t1_empty", {31'b0, readdata[12]}, 32'd1);

    // Fill behind a parked swap, overflow on the 17th word, then clear.
    push(32'h001E2000);
    for (int i = 0; i < 16; i++) push(32'h04030100 + i);
    rd_status();
    ctrl(32'h1);
    rd_status();
    ctrl(32'h2);
    ticks(2);

    // A, swap, B around a vblank edge.
    push(32'h04030001);
    push(32'h001E2000);
    push(32'h04050002);
    ticks(4);
    rd_status();
    vcount = 10'd479; tick();
    vcount = 10'd480; ticks(3);
    rd_status();

    // Swap queued while vcount sits at VACTIVE waits for the next edge.
    ticks(2);
    push(32'h001E2000);
    push(32'h04050003);
    ticks(6);
    rd_status();
    vcount = 10'd479; tick();
    vcount = 10'd480; ticks(3);

    // Flush while parked with three words queued.
    vcount = 10'd100;
    push(32'h001E2000);
    push(32'h04030011);
    push(32'h04030012);
    ticks(2);
    ctrl(32'h2);
    rd_status();
    vcount = 10'd479; tick();
    vcount = 10'd480; ticks(3);
    rd_status();

    // Randomized traffic with a rolling vcount crossing VACTIVE often.
    vc = 470;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 2500; i++) begin
        if ($urandom_range(0, 7) != 0) vc = (vc == 489) ? 470 : vc + 1;
        vcount = 10'(vc);
        r = $urandom_range(0, 99);
        if (r < 45) begin
          w = $urandom;
          if ($urandom_range(0, 4) == 0) w[20:17] = 4'hF;
          chipselect = 1; write = 1; address = 0; writedata = w;
        end else if (r < 56) begin
          chipselect = 1; read = 1; address = ($urandom_range(0, 5) != 0);
        end else if (r < 59) begin
          chipselect = 1; write = 1; address = 1; writedata = 32'h1;
        end else if (r == 59) begin
          chipselect = 1; write = 1; address = 1; writedata = 32'h2;
        end else if (r == 60) begin
          // Strobes without chipselect must be ignored.
          write = 1; read = 1; writedata = $urandom;
        end
        tick();
      end
      if (pass == 0) do_reset();
    end
    rd_status();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
